// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one byte per tx_start handshake and shifts it out
// LSB-first as start bit, 8 data bits, optional parity bit and one stop bit.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 32'sd1) ? $clog2(CLKS_PER_BIT) : 32'sd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic              PAR_EN   = (PARITY != 32'sd0);
    localparam logic              PAR_ODD  = (PARITY == 32'sd2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             parity_r, parity_s;
    logic             tx_r, tx_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             bit_end_s;

    assign bit_end_s = (baud_cnt_r == CNT_LAST);

    // Next-state, counter and next-output logic; outputs are computed one
    // cycle ahead so the line changes exactly on the bit-boundary edge.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        tx_s       = tx_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                baud_cnt_s = '0;
                if (tx_start) begin
                    state_s   = ST_START;
                    shift_s   = tx_data;
                    parity_s  = parity_bit(tx_data, PAR_ODD);
                    bit_cnt_s = 3'd0;
                    busy_s    = 1'b1;
                    tx_s      = 1'b0;
                end else begin
                    busy_s    = 1'b0;
                    tx_s      = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end_s) begin
                    state_s    = ST_DATA;
                    baud_cnt_s = '0;
                    tx_s       = shift_r[0];
                end else begin
                    baud_cnt_s = baud_cnt_r + 1'b1;
                    tx_s       = 1'b0;
                end
            end

            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_s = '0;
                    shift_s    = {1'b0, shift_r[7:1]};
                    bit_cnt_s  = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (PAR_EN) begin
                            state_s = ST_PARITY;
                            tx_s    = parity_r;
                        end else begin
                            state_s = ST_STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        // Next data bit is the one about to shift into bit 0.
                        tx_s = shift_r[1];
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + 1'b1;
                    tx_s       = shift_r[0];
                end
            end

            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s    = ST_STOP;
                    baud_cnt_s = '0;
                    tx_s       = 1'b1;
                end else begin
                    baud_cnt_s = baud_cnt_r + 1'b1;
                    tx_s       = parity_r;
                end
            end

            ST_STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    state_s    = ST_IDLE;
                    baud_cnt_s = '0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                end else begin
                    baud_cnt_s = baud_cnt_r + 1'b1;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = '0;
                bit_cnt_s  = 3'd0;
                tx_s       = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

    uart_tx_serializer_checker u_checker (
        .clk     (clk),
        .rst     (rst),
        .tx      (tx_r),
        .tx_busy (busy_r),
        .tx_done (done_r)
    );

endmodule

// Protocol invariants of the transmitter outputs.
module uart_tx_serializer_checker (
    input logic clk,
    input logic rst,
    input logic tx,
    input logic tx_busy,
    input logic tx_done
);

    a_done_not_busy : assert property (@(posedge clk) disable iff (rst) tx_done |-> !tx_busy);
    a_done_one_cycle : assert property (@(posedge clk) disable iff (rst) tx_done |=> !tx_done);
    a_idle_line_high : assert property (@(posedge clk) disable iff (rst) !tx_busy |-> tx);
    a_start_low : assert property (@(posedge clk) disable iff (rst) $rose(tx_busy) |-> !tx);

endmodule
